pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 36 +++
 rtl/pc_sequencer.sv | 116 +++++++++++
 tb/tb_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: handshake/decode bundle between the control side and the PC sequencer.
//   master : drives start, instr, decode flags (Jump, JumpR, Branch, Done), Zero, rs_data
//            and observes everything the sequencer produces.
//   slave  : the sequencer; consumes the control inputs and drives pc, pc_plus4, opcode,
//            running, halted, timeout, align_err, cycle_count and instr_count.
interface pc_sequencer_if;
    logic        start;
    logic [31:0] instr;
    logic        Jump;
    logic        JumpR;
    logic        Branch;
    logic        Done;
    logic        Zero;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic        running;
    logic        halted;
    logic        timeout;
    logic        align_err;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    modport master (
        output start, instr, Jump, JumpR, Branch, Done, Zero, rs_data,
        input  pc, pc_plus4, opcode, running, halted, timeout, align_err,
               cycle_count, instr_count
    );

    modport slave (
        input  start, instr, Jump, JumpR, Branch, Done, Zero, rs_data,
        output pc, pc_plus4, opcode, running, halted, timeout, align_err,
               cycle_count, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and run-control FSM (IDLE -> RUN -> HALTED) for a
// single-cycle MIPS-style core.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, dominates every other input
//   bus   : pc_sequencer_if.slave
//           in  : start, instr, Jump, JumpR, Branch, Done, Zero, rs_data
//           out : pc, pc_plus4, opcode, running, halted, timeout (sticky),
//                 align_err (sticky), cycle_count, instr_count
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MAX_CYCLES = 4096
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e      stateQ, stateD;
    logic [31:0] pcQ, pcD;
    logic [31:0] cycleCountQ, cycleCountD;
    logic [31:0] instrCountQ, instrCountD;
    logic        timeoutQ, timeoutD;
    logic        alignErrQ, alignErrD;

    logic [31:0] pcPlus4;
    logic [31:0] branchOffset;
    logic [31:0] nextPc;
    logic        wdFire;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // All address arithmetic wraps modulo 2^32.
    assign pcPlus4      = pcQ + 32'd4;
    assign branchOffset = {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
    assign wdFire       = (cycleCountQ == 32'(MAX_CYCLES - 1));

    always_comb begin
        nextPc = pcPlus4;
        if (bus.JumpR) begin
            nextPc = {bus.rs_data[31:2], 2'b00};
        end else if (bus.Jump) begin
            nextPc = {pcPlus4[31:28], bus.instr[25:0], 2'b00};
        end else if (bus.Branch && bus.Zero) begin
            nextPc = pcPlus4 + branchOffset;
        end
    end

    always_comb begin
        stateD      = stateQ;
        pcD         = pcQ;
        cycleCountD = cycleCountQ;
        instrCountD = instrCountQ;
        timeoutD    = timeoutQ;
        alignErrD   = alignErrQ;
        unique case (stateQ)
            StIdle, StHalted: begin
                if (bus.start) begin
                    stateD      = StRun;
                    pcD         = RESET_PC;
                    cycleCountD = '0;
                    instrCountD = '0;
                    timeoutD    = 1'b0;
                    alignErrD   = 1'b0;
                end
            end
            StRun: begin
                cycleCountD = satInc(cycleCountQ);
                // Done wins over a watchdog expiry in the same cycle.
                if (bus.Done) begin
                    stateD = StHalted;
                end else if (wdFire) begin
                    stateD   = StHalted;
                    timeoutD = 1'b1;
                end else begin
                    pcD         = nextPc;
                    instrCountD = satInc(instrCountQ);
                    if (bus.JumpR && (bus.rs_data[1:0] != 2'b00)) begin
                        alignErrD = 1'b1;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ      <= StIdle;
            pcQ         <= RESET_PC;
            cycleCountQ <= '0;
            instrCountQ <= '0;
            timeoutQ    <= 1'b0;
            alignErrQ   <= 1'b0;
        end else begin
            stateQ      <= stateD;
            pcQ         <= pcD;
            cycleCountQ <= cycleCountD;
            instrCountQ <= instrCountD;
            timeoutQ    <= timeoutD;
            alignErrQ   <= alignErrD;
        end
    end

    assign bus.pc          = pcQ;
    assign bus.pc_plus4    = pcPlus4;
    assign bus.opcode      = bus.instr[31:26];
    assign bus.running     = (stateQ == StRun);
    assign bus.halted      = (stateQ == StHalted);
    assign bus.timeout     = timeoutQ;
    assign bus.align_err   = alignErrQ;
    assign bus.cycle_count = cycleCountQ;
    assign bus.instr_count = instrCountQ;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pc_sequencer_if bus ();
    pc_sequencer_if bus2 ();

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .MAX_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    pc_sequencer #(
        .RESET_PC   (32'hFFFF_FFFC),
        .MAX_CYCLES (4096)
    ) dutWrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        bus.start   = 1'b0;
        bus.instr   = 32'h0;
        bus.Jump    = 1'b0;
        bus.JumpR   = 1'b0;
        bus.Branch  = 1'b0;
        bus.Done    = 1'b0;
        bus.Zero    = 1'b0;
        bus.rs_data = 32'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        clearIn();
        bus2.start   = 1'b0;
        bus2.instr   = 32'h0;
        bus2.Jump    = 1'b0;
        bus2.JumpR   = 1'b0;
        bus2.Branch  = 1'b0;
        bus2.Done    = 1'b0;
        bus2.Zero    = 1'b0;
        bus2.rs_data = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_pc", bus.pc, 32'h0);
        check("rst_running", 32'(bus.running), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_cyc", bus.cycle_count, 32'd0);
        check("rst_ins", bus.instr_count, 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        check("rst_align", 32'(bus.align_err), 32'd0);
        bus.instr = 32'hFC00_0000;
        #1;
        check("opcode_idle", 32'(bus.opcode), 32'h3F);
        bus.instr = 32'h0;

        // Straight line 0,4,8,12 then halt
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("sl_running", 32'(bus.running), 32'd1);
        check("sl_pc0", bus.pc, 32'h0);
        tick();
        check("sl_pc4", bus.pc, 32'h4);
        tick();
        check("sl_pc8", bus.pc, 32'h8);
        tick();
        check("sl_pc12", bus.pc, 32'hC);
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        check("sl_halt_pc", bus.pc, 32'hC);
        check("sl_halted", 32'(bus.halted), 32'd1);
        check("sl_running_lo", 32'(bus.running), 32'd0);
        check("sl_ins", bus.instr_count, 32'd3);
        check("sl_cyc", bus.cycle_count, 32'd4);

        // Decode ignored while HALTED
        bus.Jump  = 1'b1;
        bus.Done  = 1'b1;
        bus.instr = 32'h0800_0040;
        tick();
        clearIn();
        check("hold_pc", bus.pc, 32'hC);
        check("hold_cyc", bus.cycle_count, 32'd4);
        check("hold_halted", 32'(bus.halted), 32'd1);

        // Restart from HALTED, then branches
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("rs_pc", bus.pc, 32'h0);
        check("rs_cyc", bus.cycle_count, 32'd0);
        check("rs_ins", bus.instr_count, 32'd0);
        check("rs_running", 32'(bus.running), 32'd1);
        tick();
        tick();
        check("br_pre_pc", bus.pc, 32'h8);
        bus.Branch = 1'b1;
        bus.Zero   = 1'b1;
        bus.instr  = 32'h1000_FFFE;
        tick();
        check("beq_taken", bus.pc, 32'h4);
        clearIn();
        tick();
        bus.Branch = 1'b1;
        bus.Zero   = 1'b0;
        bus.instr  = 32'h1000_FFFE;
        tick();
        check("beq_not_taken", bus.pc, 32'hC);
        clearIn();
        bus.Done = 1'b1;
        tick();
        clearIn();
        check("br_ins", bus.instr_count, 32'd5);
        check("br_cyc", bus.cycle_count, 32'd6);

        // Jump and jr
        bus.start = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.JumpR   = 1'b1;
        bus.rs_data = 32'h1000_0000;
        tick();
        check("jr_pc", bus.pc, 32'h1000_0000);
        clearIn();
        bus.Jump  = 1'b1;
        bus.instr = 32'h0800_0040;
        tick();
        check("j_pc", bus.pc, 32'h1000_0100);
        check("j_align", 32'(bus.align_err), 32'd0);
        clearIn();
        bus.JumpR   = 1'b1;
        bus.Jump    = 1'b1;
        bus.rs_data = 32'h0000_0203;
        bus.instr   = 32'h0800_0040;
        tick();
        check("jr_prio_pc", bus.pc, 32'h200);
        check("jr_align", 32'(bus.align_err), 32'd1);

        // start while RUN is ignored
        clearIn();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("run_start_pc", bus.pc, 32'h204);
        check("run_start_ins", bus.instr_count, 32'd4);
        check("run_start_align", 32'(bus.align_err), 32'd1);
        bus.Jump  = 1'b1;
        bus.instr = 32'h0800_0010;
        tick();
        check("j40_pc", bus.pc, 32'h40);

        // Reset mid-RUN
        clearIn();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_pc", bus.pc, 32'h0);
        check("mr_running", 32'(bus.running), 32'd0);
        check("mr_halted", 32'(bus.halted), 32'd0);
        check("mr_cyc", bus.cycle_count, 32'd0);
        check("mr_ins", bus.instr_count, 32'd0);
        check("mr_align", 32'(bus.align_err), 32'd0);

        // Watchdog with a self-loop (beq offset -4)
        bus.start = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.Branch = 1'b1;
        bus.Zero   = 1'b1;
        bus.instr  = 32'h1000_FFFF;
        repeat (7) tick();
        check("wd_pre_running", 32'(bus.running), 32'd1);
        check("wd_pre_cyc", bus.cycle_count, 32'd7);
        check("wd_pre_to", 32'(bus.timeout), 32'd0);
        tick();
        check("wd_halted", 32'(bus.halted), 32'd1);
        check("wd_timeout", 32'(bus.timeout), 32'd1);
        check("wd_cyc", bus.cycle_count, 32'd8);
        check("wd_ins", bus.instr_count, 32'd7);
        check("wd_pc", bus.pc, 32'h0);

        // Done coinciding with the watchdog resolves as halt
        clearIn();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("wd2_to_clr", 32'(bus.timeout), 32'd0);
        check("wd2_pc", bus.pc, 32'h0);
        bus.Branch = 1'b1;
        bus.Zero   = 1'b1;
        bus.instr  = 32'h1000_FFFF;
        repeat (7) tick();
        bus.Done = 1'b1;
        tick();
        clearIn();
        check("wd2_halted", 32'(bus.halted), 32'd1);
        check("wd2_timeout", 32'(bus.timeout), 32'd0);
        check("wd2_cyc", bus.cycle_count, 32'd8);
        check("wd2_ins", bus.instr_count, 32'd7);

        // Address wrap
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        check("wrap_pc0", bus2.pc, 32'hFFFF_FFFC);
        check("wrap_plus4", bus2.pc_plus4, 32'h0);
        tick();
        check("wrap_pc1", bus2.pc, 32'h0);
        check("wrap_ins", bus2.instr_count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout_guard observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
